tick_sequencer: RTL

Tick-paced LED pattern sequencer that consumes the one-cycle tick produced by the divide-down delay stage. It holds a small writable pattern memory and, while running, advances through it one entry per programmed number of ticks, driving the LED bank. It sits between the tick generator and the board LEDs, with a write port for the CPU/RAM side to load patterns.

---
 rtl/tick_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/tick_sequencer.sv
// tick_sequencer: tick-paced LED pattern sequencer with a writable pattern memory.
// Ports:
//   mclk     clock, all logic on posedge
//   rst      synchronous active-high reset
//   tick     one-cycle pacing pulse from the delay stage
//   run      level, high = sequence, low = pause
//   step     one-cycle single-step pulse while paused
//   wr_en    pattern memory write strobe
//   wr_addr  write address
//   wr_data  entry {last, hold[2:0], pattern}
//   led      current pattern (registered)
//   addr     index of current entry (registered)
//   running  high while in RUN
//   wrap     one-cycle pulse when the sequence returns to entry 0
// Build option: define TICK_SEQ_STEP_EN to make step functional; otherwise step is ignored.
module tick_sequencer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LED_WIDTH  = 8
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  run,
    input  logic                  step,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [LED_WIDTH+3:0]  wr_data,
    output logic [LED_WIDTH-1:0]  led,
    output logic [DEPTH_LOG2-1:0] addr,
    output logic                  running,
    output logic                  wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
    state_e                state_q, state_d;
    logic [LED_WIDTH+3:0]  mem_q [2**DEPTH_LOG2];
    logic [LED_WIDTH-1:0]  led_q;
    logic [DEPTH_LOG2-1:0] addr_q, idx;
    logic [2:0]            hold_q;
    logic                  last_q, wrap_q;
    logic                  step_en, fetch, adv, dec, wrap_d;
    logic [LED_WIDTH+3:0]  entry;
`ifdef TICK_SEQ_STEP_EN
    assign step_en = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_en = 1'b0;
`endif
    always_ff @(posedge mclk)
        if (wr_en) mem_q[wr_addr] <= wr_data;
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= IDLE;
            led_q   <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            if (fetch || adv) begin
                led_q  <= entry[LED_WIDTH-1:0];
                addr_q <= idx;
                hold_q <= entry[LED_WIDTH+2:LED_WIDTH];
                last_q <= entry[LED_WIDTH+3];
            end else if (dec) begin
                hold_q <= hold_q - 3'd1;
            end
        end
    end
    // A tick in the cycle run drops is ignored; run has priority over step in PAUSE.
    always_comb begin
        state_d = state_q;
        fetch   = 1'b0;
        adv     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE:  if (run) begin state_d = RUN; fetch = 1'b1; end
            RUN:   if (!run) state_d = PAUSE;
                   else if (tick) begin dec = hold_q != 3'd0; adv = hold_q == 3'd0; end
            PAUSE: if (run) state_d = RUN;
                   else adv = step_en;
            default: state_d = IDLE;
        endcase
        // last is latched at fetch so a later write to the live entry cannot alter its wrap
        wrap_d = adv && (last_q || &addr_q);
        idx    = (fetch || wrap_d) ? '0 : addr_q + 1'b1;
        entry  = mem_q[idx];
    end
    always_comb begin
        led     = led_q;
        addr    = addr_q;
        running = state_q == RUN;
        wrap    = wrap_q;
    end
endmodule
